// File: rtl/spawn_pkg.sv
// Shared types and default constants for the spawn scheduler.
package spawn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int MOD_DEF   = 479;
    localparam int NUM_W_DEF = 11;
    localparam int GAP_DEF   = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   winner
);

    // Scan ptr..NREQ-1 first, then 0..ptr-1, so the first hit is the RR winner.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (PW'(i) >= ptr)) begin
                any    = 1'b1;
                winner = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (PW'(i) < ptr)) begin
                any    = 1'b1;
                winner = PW'(i);
            end
        end
    end

endmodule

// File: rtl/spawn_sched.sv
// Round-robin spawn scheduler: grants one spawner at a time, issues a
// de-duplicated random value with the grant, then enforces a cooldown.
module spawn_sched
    import spawn_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NUM_W   = NUM_W_DEF,
    parameter int MOD     = MOD_DEF,
    parameter int GAP_MIN = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [NUM_W-1:0] num,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NUM_W-1:0] val,
    output logic             val_vld,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 10;
    localparam logic [CW-1:0]    CNT_INIT = (GAP_MIN > 0) ? CW'(GAP_MIN - 1) : '0;
    localparam logic [NUM_W-1:0] MODV     = NUM_W'(MOD);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [NUM_W-1:0] r_val;
    logic             r_vld;
    logic             r_busy;

    logic             w_any;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]  w_onehot;
    logic [NUM_W-1:0] w_fold;
    logic [NUM_W-1:0] w_inc;
    logic [NUM_W-1:0] w_wrap;
    logic [NUM_W-1:0] w_issue;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_win)
    );

    // Value path and next-pointer; r_val doubles as last_val since val
    // always holds the most recently issued value.
    always_comb begin
        w_fold    = (num < MODV) ? num : num - MODV;
        w_inc     = w_fold + NUM_W'(1);
        w_wrap    = NUM_W'(32'(w_inc) % MOD);
        w_issue   = (w_fold == r_val) ? w_wrap : w_fold;
        w_onehot  = NREQ'(1) << w_win;
        w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
    end

    // Scheduler FSM with registered grant, value, valid and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_val   <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= '0;
                    r_vld <= 1'b0;
                    if (run && w_any) begin
                        r_gnt   <= w_onehot;
                        r_val   <= w_issue;
                        r_vld   <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    r_vld <= 1'b0;
                    if (GAP_MIN == 0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ST_COOLDOWN: begin
                    if (run) begin
                        if (r_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign val     = r_val;
    assign val_vld = r_vld;
    assign busy    = r_busy;

endmodule

// File: doc/spawn_sched.md
# spawn_sched

Round-robin scheduler that shares the free-running random-number source (0..478, 11 bits) among several game-object spawners (obstacle lanes, coins, etc.) in the Running Pig design. Each spawner raises a level request. The block grants one spawner at a time, hands it a sampled, de-duplicated random value, and enforces a minimum gap between spawns so objects never appear on top of each other. It sits between the random generator and the spawner logic in the game core.

## Interface
Parameters:
- NREQ, 4, number of requesting spawners (2..8)
- NUM_W, 11, width of the random value
- MOD, 479, range of valid values (0..MOD-1)
- GAP_MIN, 16, cooldown cycles after each grant (0..1023)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  game running; 0 pauses scheduling
- num  in  NUM_W  current value from the random generator
- req  in  NREQ  per-spawner request, level; held until granted
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- val  out  NUM_W  value issued with the grant; holds the last issued value otherwise
- val_vld  out  1  high exactly in the cycle gnt is non-zero
- busy  out  1  high in GRANT and COOLDOWN states

## Operation
- State machine: IDLE, GRANT, COOLDOWN.
- IDLE with run=1 and any req bit set:
  - pick the winner: the first set bit at or after ptr, scanning upward with wrap at NREQ;
  - register gnt=onehot(winner);
  - compute val from num;
  - set ptr=(winner+1) mod NREQ;
  - go to GRANT.
- IDLE with run=0: no grant is made and the state stays IDLE.
- GRANT lasts one cycle, with gnt and val_vld high.
  - Next state is COOLDOWN with cnt=GAP_MIN-1.
  - If GAP_MIN=0, next state is IDLE.
  - GRANT always completes, regardless of run.
- COOLDOWN:
  - run=1: decrement cnt; when cnt=0, go to IDLE.
  - run=0: cnt freezes.
- Value rule:
  - r = num if num<MOD, else num-MOD (defensive fold).
  - If r equals last_val, issue (r+1) mod MOD instead; otherwise issue r.
  - last_val updates to the issued value on every grant.
  - All arithmetic is NUM_W bits, unsigned.
- Requests that drop before being granted are simply not served; there is no queueing.
- req bits for the currently granted spawner are ignored until the next IDLE evaluation.
- Reset values:
  - state=IDLE, ptr=0, cnt=0, last_val=0;
  - gnt=0, val=0, val_vld=0, busy=0.
- Reset mid-operation aborts any GRANT or COOLDOWN immediately, with no pulse emitted afterwards.

## Timing
- Request visible in IDLE at edge t → gnt, val and val_vld high in cycle t+1 (registered; 1-cycle latency).
- Minimum grant spacing is GAP_MIN+2 cycles (grant, GAP_MIN cooldown cycles, one IDLE evaluation cycle). With GAP_MIN=0 the spacing is 2.
- val is sampled from num at the IDLE decision edge, not in the GRANT cycle.
- Simultaneous requests: round-robin order only; with all bits held, grants rotate 0,1,2,3,0,...
- run deasserted during COOLDOWN extends the cooldown by exactly the number of paused cycles.

## Structure
- Shared package spawn_pkg holds:
  - the state typedef (IDLE, GRANT, COOLDOWN);
  - default constants: MOD_DEF=479, NUM_W_DEF=11, GAP_DEF=16.
- One combinational sub-module, rr_pick (inputs: req, ptr; outputs: any, winner index). It is instantiated once; the FSM, counter and value logic stay in spawn_sched.

## Test plan
- Reset behaviour: rst=1 for 2 cycles, then req=4'b0001, num=100 → gnt=0001, val=100, val_vld=1 exactly one cycle after the first post-reset IDLE edge; busy=1 for 17 cycles.
- Rotation: req=4'b1111 held, GAP_MIN=16 → grants in order 0,1,2,3,0, spaced exactly 18 cycles apart.
- De-duplication: two grants with num=478 at both decisions → val=478, then 0 (wrap). Out-of-range num=500 → val=21.
- Pause: run dropped for 5 cycles mid-COOLDOWN → next grant is 23 cycles after the previous one. run=0 in IDLE with req set → no gnt.
- Skip and wrap: ptr=3, req=4'b0100 → gnt=0100, then ptr=3. Next, req=4'b0011 → gnt=0001.
- Mid-operation reset: rst asserted during GRANT → gnt=0 and val_vld=0 from the next cycle. ptr=0, and last_val=0 is verified by num=0 yielding val=1.
